// File: rtl/pixel_plane_split.sv
// Purpose: expand, dim and bit-plane-slice one packed RGB pixel per panel lane into per-lane R/G/B output bits.
// Latency: 2 cycles from accept to out_valid; one beat per cycle at full rate.
// Backpressure: one global advance; both stages hold and in_ready drops while out_valid & ~out_ready.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   pixel_data / in_valid / in_ready
//                                one pixel word per lane, lane l at [l*PIXEL_WIDTH +: PIXEL_WIDTH]
//   bitplane, channel_scale, rgb_enable, blank
//                                per-beat controls, captured on accept
//   rgb_output / out_valid / out_ready
//                                lane l: [3l] red, [3l+1] green, [3l+2] blue
module pixel_plane_split #(
    parameter  int LANES             = 2,
    parameter  int PIXEL_FORMAT      = 0,
    parameter  int BRIGHTNESS_LEVELS = 8,
    localparam int PIXEL_WIDTH       = (PIXEL_FORMAT == 1) ? 24 : 16,
    localparam int BP_W              = $clog2(BRIGHTNESS_LEVELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LANES*PIXEL_WIDTH-1:0] pixel_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BP_W-1:0]              bitplane,
    input  logic [23:0]                  channel_scale,
    input  logic [2:0]                   rgb_enable,
    input  logic                         blank,
    output logic [3*LANES-1:0]           rgb_output,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int B     = BRIGHTNESS_LEVELS;
    localparam int MAX_B = (PIXEL_FORMAT == 1) ? 16 : 10;
    localparam int S1_W  = LANES * 3 * B;

    // Out-of-range indices only exist for non-power-of-2 level counts.
    localparam logic [BP_W:0] B_LIM = (BP_W + 1)'(B);

    if (PIXEL_FORMAT != 0 && PIXEL_FORMAT != 1) begin : g_bad_format
        $error("pixel_plane_split: PIXEL_FORMAT must be 0 or 1");
    end
    if (B < 4 || B > MAX_B) begin : g_bad_levels
        $error("pixel_plane_split: BRIGHTNESS_LEVELS out of range for PIXEL_FORMAT");
    end

    // Stage 1: scaled components and the controls that travel with them.
    logic [S1_W-1:0]   s1_q, s1_d;
    logic [BP_W-1:0]   bp_q, bp_d;
    logic [2:0]        en_q, en_d;
    logic              blank_q, blank_d;
    logic              v1_q, v1_d;
    // Stage 2: output bits.
    logic [3*LANES-1:0] rgb_q, rgb_d;
    logic               ov_q, ov_d;

    logic               adv;
    logic               accept;
    logic               bp_ok;
    logic [S1_W-1:0]    scaled;
    logic [3*LANES-1:0] plane;

    assign adv      = ~ov_q | out_ready;
    assign in_ready = adv & ~reset;
    assign accept   = in_valid & in_ready;
    assign bp_ok    = {1'b0, bp_q} < B_LIM;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar c = 0; c < 3; c++) begin : g_ch
            localparam int W   = (PIXEL_FORMAT == 1) ? 8 : ((c == 1) ? 6 : 5);
            localparam int LSB = (PIXEL_FORMAT == 1) ? (16 - 8 * c)
                                                     : ((c == 0) ? 11 : ((c == 1) ? 5 : 0));

            logic [W-1:0] comp;
            logic [B-1:0] expd;
            logic [B+8:0] prod;
            logic [B-1:0] s1_c;

            assign comp = pixel_data[l*PIXEL_WIDTH + LSB +: W];

            // Narrow components refill their low bits from their own MSBs so full scale maps to all-ones.
            if (W >= B) begin : g_trunc
                assign expd = comp[W-1 -: B];
            end else begin : g_rep
                assign expd = {comp, comp[W-1 -: B-W]};
            end

            // (scale+1)/256 makes 8'hFF an exact identity; the shifted product always fits in B bits.
            assign prod = {9'd0, expd} * {{B{1'b0}}, {1'b0, channel_scale[8*c +: 8]} + 9'd1};
            assign scaled[(l*3+c)*B +: B] = B'(prod >> 8);

            assign s1_c = s1_q[(l*3+c)*B +: B];
            assign plane[3*l+c] = bp_ok & en_q[c] & ~blank_q & (|(s1_c & (B'(1) << bp_q)));
        end
    end

    always_comb begin
        s1_d    = s1_q;
        bp_d    = bp_q;
        en_d    = en_q;
        blank_d = blank_q;
        v1_d    = v1_q;
        rgb_d   = rgb_q;
        ov_d    = ov_q;
        if (adv) begin
            v1_d  = accept;
            ov_d  = v1_q;
            rgb_d = plane;
        end
        if (accept) begin
            s1_d    = scaled;
            bp_d    = bitplane;
            en_d    = rgb_enable;
            blank_d = blank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            bp_q    <= '0;
            en_q    <= '0;
            blank_q <= 1'b0;
            v1_q    <= 1'b0;
            rgb_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            bp_q    <= bp_d;
            en_q    <= en_d;
            blank_q <= blank_d;
            v1_q    <= v1_d;
            rgb_q   <= rgb_d;
            ov_q    <= ov_d;
        end
    end

    assign rgb_output = rgb_q;
    assign out_valid  = ov_q;

endmodule

// File: tb/tb_pixel_plane_split.sv
// Bench for pixel_plane_split: one RGB565 and one RGB888 instance (LANES=2, 8 planes) share all controls.
module tb_pixel_plane_split;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pix565;
    logic [47:0] pix888;
    logic        in_valid;
    logic [2:0]  bitplane;
    logic [23:0] channel_scale;
    logic [2:0]  rgb_enable;
    logic        blank;
    logic        out_ready;
    logic        rdy565, rdy888, ov565, ov888;
    logic [5:0]  rgb565, rgb888;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] p565;
        logic [47:0] p888;
        logic [2:0]  bp;
        logic [23:0] sc;
        logic [2:0]  en;
        logic        bl;
    } beat_t;

    typedef struct {
        logic [5:0] e565;
        logic [5:0] e888;
    } exp_t;

    always #5 clk = ~clk;

    pixel_plane_split #(.LANES(2), .PIXEL_FORMAT(0), .BRIGHTNESS_LEVELS(8)) u_dut565 (
        .clk(clk), .reset(reset), .pixel_data(pix565), .in_valid(in_valid), .in_ready(rdy565),
        .bitplane(bitplane), .channel_scale(channel_scale), .rgb_enable(rgb_enable), .blank(blank),
        .rgb_output(rgb565), .out_valid(ov565), .out_ready(out_ready));

    pixel_plane_split #(.LANES(2), .PIXEL_FORMAT(1), .BRIGHTNESS_LEVELS(8)) u_dut888 (
        .clk(clk), .reset(reset), .pixel_data(pix888), .in_valid(in_valid), .in_ready(rdy888),
        .bitplane(bitplane), .channel_scale(channel_scale), .rgb_enable(rgb_enable), .blank(blank),
        .rgb_output(rgb888), .out_valid(ov888), .out_ready(out_ready));

    // Reference: component extraction, MSB-replicating expansion to 8 bits, (scale+1)/256 dimming, plane pick.
    function automatic logic [5:0] model(input bit fmt, input beat_t b);
        logic [5:0]  r;
        logic [47:0] word;
        int w, sh, comp, e, k, s;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            word = fmt ? ((b.p888 >> (24*l)) & 48'hFFFFFF) : ({16'd0, b.p565} >> (16*l)) & 48'hFFFF;
            for (int c = 0; c < 3; c++) begin
                w    = fmt ? 8 : ((c == 1) ? 6 : 5);
                sh   = fmt ? (16 - 8*c) : ((c == 0) ? 11 : ((c == 1) ? 5 : 0));
                comp = int'((word >> sh) & 48'((1 << w) - 1));
                if (w >= 8) e = comp >> (w - 8);
                else        e = (comp << (8 - w)) | (comp >> (2*w - 8));
                k    = int'((b.sc >> (8*c)) & 24'hFF);
                s    = ((e * (k + 1)) >> 8) & 255;
                r[3*l+c] = !b.bl && b.en[c] && (((s >> b.bp) & 1) == 1);
            end
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.p565 = $urandom;
        b.p888 = {16'($urandom), $urandom};
        b.bp   = 3'($urandom);
        case ($urandom_range(0, 3))
            0:       b.sc = 24'h000000;
            1:       b.sc = 24'hFFFFFF;
            default: b.sc = 24'($urandom);
        endcase
        b.en = 3'($urandom);
        b.bl = ($urandom_range(0, 7) == 0);
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        pix565 = b.p565; pix888 = b.p888; bitplane = b.bp; channel_scale = b.sc;
        rgb_enable = b.en; blank = b.bl; in_valid = v;
    endtask

    task automatic flush();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Drives one beat into an empty pipe and samples out_valid one and two edges after accept.
    task automatic one_beat(input beat_t b, output logic rdy, output logic ov_n1, output logic ov_n2,
                            output logic [5:0] o565, output logic [5:0] o888);
        drive(b, 1'b1); out_ready = 1'b1;
        #1; rdy = rdy565 & rdy888;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1; ov_n1 = ov565 | ov888;
        @(posedge clk); #1;
        ov_n2 = ov565 & ov888; o565 = rgb565; o888 = rgb888;
    endtask

    task automatic test_reset();
        beat_t b;
        b = '{p565: 32'h0, p888: 48'h0, bp: 3'd0, sc: 24'h0, en: 3'd0, bl: 1'b0};
        drive(b, 1'b0); out_ready = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if ({ov565, ov888} !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b required 00", {ov565, ov888}); end
        n_tests++; if ({rgb565, rgb888} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h required 000", {rgb565, rgb888}); end
        n_tests++; if ({rdy565, rdy888} !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready_low: got %b required 00", {rdy565, rdy888}); end
        reset = 1'b0; #1;
        n_tests++; if ({rdy565, rdy888} !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready_after: got %b required 11", {rdy565, rdy888}); end
        @(posedge clk); #1;
    endtask

    task automatic test_rgb565_planes();
        beat_t b; logic rdy, ov1, ov2; logic [5:0] o565, o888;
        flush();
        b = '{p565: {16'h001F, 16'hF800}, p888: 48'h123456_89ABCD, bp: 3'd7, sc: 24'hFFFFFF, en: 3'b111, bl: 1'b0};
        for (int i = 0; i < 2; i++) begin
            b.bp = (i == 0) ? 3'd7 : 3'd2;
            one_beat(b, rdy, ov1, ov2, o565, o888);
            n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rgb565_in_ready: got %b required 1", rdy); end
            n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL rgb565_latency_early: out_valid %b at N+1, required 0", ov1); end
            n_tests++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL rgb565_latency: out_valid %b at N+2, required 1", ov2); end
            n_tests++; if (o565 !== 6'b100_001) begin n_fail++; $display("FAIL rgb565_plane%0d: got %b required 100001", b.bp, o565); end
            n_tests++; if (o888 !== model(1'b1, b)) begin n_fail++; $display("FAIL rgb565_peer888: got %b required %b", o888, model(1'b1, b)); end
        end
    endtask

    task automatic test_rgb888_scale();
        beat_t b; logic rdy, ov1, ov2; logic [5:0] o565, o888;
        flush();
        b = '{p565: 32'h0, p888: {24'h000000, 24'h800000}, bp: 3'd6, sc: 24'h7F7F7F, en: 3'b111, bl: 1'b0};
        one_beat(b, rdy, ov1, ov2, o565, o888);
        n_tests++; if (o888[0] !== 1'b1) begin n_fail++; $display("FAIL rgb888_bit6: got %b required 1", o888[0]); end
        n_tests++; if (o888 !== 6'b000_001) begin n_fail++; $display("FAIL rgb888_word6: got %b required 000001", o888); end
        b.bp = 3'd7;
        one_beat(b, rdy, ov1, ov2, o565, o888);
        n_tests++; if (o888[0] !== 1'b0) begin n_fail++; $display("FAIL rgb888_bit7: got %b required 0", o888[0]); end
        n_tests++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL rgb888_valid: got %b required 1", ov2); end
    endtask

    task automatic test_gating();
        beat_t b; logic rdy, ov1, ov2; logic [5:0] o565, o888;
        flush();
        b = '{p565: 32'hFFFFFFFF, p888: 48'hFFFFFF_FFFFFF, bp: 3'($urandom), sc: 24'hFFFFFF, en: 3'b010, bl: 1'b0};
        one_beat(b, rdy, ov1, ov2, o565, o888);
        n_tests++; if (o888 !== 6'b010_010) begin n_fail++; $display("FAIL gating_green888: got %b required 010010", o888); end
        n_tests++; if (o565 !== 6'b010_010) begin n_fail++; $display("FAIL gating_green565: got %b required 010010", o565); end
        b.bl = 1'b1;
        one_beat(b, rdy, ov1, ov2, o565, o888);
        n_tests++; if ({o565, o888} !== 12'h000) begin n_fail++; $display("FAIL gating_blank: got %h required 000", {o565, o888}); end
        n_tests++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL gating_blank_valid: got %b required 1", ov2); end
    endtask

    // mode 0: full rate, bitplane cycles; mode 1: 3-cycle stall at first out_valid; mode 2: random valid/ready.
    task automatic run_stream(input int nbeats, input int mode, input string name);
        exp_t       q[$];
        exp_t       x;
        beat_t      cur;
        logic       have, hold_prev;
        logic [5:0] held565, held888;
        int         sent, got, cyc, first_ov;
        flush();
        have = 1'b0; hold_prev = 1'b0; sent = 0; got = 0; cyc = 0; first_ov = -1;
        held565 = '0; held888 = '0;
        while (got < nbeats && cyc < 600) begin
            if (!have && sent < nbeats && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                cur = rand_beat();
                if (mode == 0) cur.bp = 3'(sent % 8);
                have = 1'b1;
            end
            drive(cur, have);
            if (mode == 1 && first_ov < 0 && ov565) first_ov = cyc;
            case (mode)
                1:       out_ready = !(first_ov >= 0 && cyc < first_ov + 3);
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            #1;
            if (hold_prev) begin
                n_tests++;
                if ({ov565, ov888, rgb565, rgb888} !== {2'b11, held565, held888}) begin
                    n_fail++; $display("FAIL %s_hold: got %b/%h required 11/%h", name, {ov565, ov888}, {rgb565, rgb888}, {held565, held888});
                end
            end
            hold_prev = 1'b0;
            if (ov565 && !out_ready) begin
                n_tests++; if ({rdy565, rdy888} !== 2'b00) begin n_fail++; $display("FAIL %s_stall_in_ready: got %b required 00", name, {rdy565, rdy888}); end
                hold_prev = 1'b1; held565 = rgb565; held888 = rgb888;
            end
            if (mode == 0 && cyc >= 2) begin
                n_tests++; if (ov565 !== 1'b1) begin n_fail++; $display("FAIL %s_continuous: out_valid %b at cycle %0d required 1", name, ov565, cyc); end
            end
            if (ov565 && out_ready) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL %s_spurious: out_valid 1 with nothing outstanding, required 0", name);
                end else begin
                    x = q.pop_front();
                    if ({rgb565, rgb888} !== {x.e565, x.e888}) begin
                        n_fail++; $display("FAIL %s_data beat %0d: got %b_%b required %b_%b", name, got, rgb565, rgb888, x.e565, x.e888);
                    end
                end
                got++;
            end
            if (have && rdy565) begin
                x.e565 = model(1'b0, cur); x.e888 = model(1'b1, cur);
                q.push_back(x);
                sent++; have = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_tests++; if (got != nbeats) begin n_fail++; $display("FAIL %s_timeout: got %0d beats required %0d", name, got, nbeats); end
        out_ready = 1'b1;
        repeat (3) begin
            #1;
            n_tests++; if ({ov565, ov888} !== 2'b00) begin n_fail++; $display("FAIL %s_extra: out_valid %b after stream, required 00", name, {ov565, ov888}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midstream();
        beat_t b;
        flush();
        b = rand_beat(); drive(b, 1'b1); out_ready = 1'b1;
        @(posedge clk); #1;
        b = rand_beat(); drive(b, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; reset = 1'b1; #1;
        n_tests++; if (ov565 !== 1'b1) begin n_fail++; $display("FAIL midreset_inflight: out_valid %b required 1", ov565); end
        n_tests++; if ({rdy565, rdy888} !== 2'b00) begin n_fail++; $display("FAIL midreset_in_ready_low: got %b required 00", {rdy565, rdy888}); end
        @(posedge clk); #1;
        reset = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            n_tests++; if ({ov565, ov888} !== 2'b00) begin n_fail++; $display("FAIL midreset_out_valid cycle %0d: got %b required 00", i, {ov565, ov888}); end
            n_tests++; if ({rgb565, rgb888} !== 12'h000) begin n_fail++; $display("FAIL midreset_rgb cycle %0d: got %h required 000", i, {rgb565, rgb888}); end
            n_tests++; if ({rdy565, rdy888} !== 2'b11) begin n_fail++; $display("FAIL midreset_in_ready cycle %0d: got %b required 11", i, {rdy565, rdy888}); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_rgb565_planes();
        test_rgb888_scale();
        test_gating();
        run_stream(4, 1, "backpressure");
        test_reset_midstream();
        run_stream(16, 0, "back_to_back");
        run_stream(60, 2, "random");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
